// File: rtl/dmem_arbiter.sv
// Two-port (CPU / host) round-robin controller for a small word-addressed data memory.
// Define DMEM_ARB_STATS_EN to add saturating grant/conflict counters.
module dmem_arbiter #(
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    output logic        cpu_err,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [31:0] host_addr,
    input  logic [31:0] host_wdata,
    output logic [31:0] host_rdata,
    output logic        host_ready,
    output logic        host_err,
    output logic [1:0]  grant,
    output logic        busy,
`ifdef DMEM_ARB_STATS_EN
    output logic [15:0] cpu_grants,
    output logic [15:0] host_grants,
    output logic [15:0] conflicts,
`endif
    output logic [31:0] mem_word0
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    localparam logic OWNER_CPU  = 1'b0;
    localparam logic OWNER_HOST = 1'b1;

    logic [1:0]    state_r;
    logic          owner_r;
    logic          last_grant_r;
    logic          we_r;
    logic [31:2]   addr_r;
    logic [31:0]   wdata_r;
    logic [31:0]   mem_r [DEPTH];

    logic [AW-1:0] idx_s;
    logic          oor_s;
    logic [31:0]   result_s;
    logic          conflict_s;
    logic          grant_host_s;
    logic          unused_s;

    // Byte offsets are never used; words only.
    assign unused_s = ^{cpu_addr[1:0], host_addr[1:0]};

    // Arbitration decision and access result for the latched transaction.
    always_comb begin
        idx_s      = addr_r[AW+1:2];
        oor_s      = |addr_r[31:AW+2];
        conflict_s = cpu_req & host_req;
        if (conflict_s) begin
            grant_host_s = (last_grant_r == OWNER_CPU);
        end else begin
            grant_host_s = host_req;
        end
        if (we_r) begin
            result_s = wdata_r;
        end else if (oor_s) begin
            result_s = 32'd0;
        end else begin
            result_s = mem_r[idx_s];
        end
    end

    // Transaction FSM with registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            owner_r      <= OWNER_CPU;
            last_grant_r <= OWNER_HOST;
            we_r         <= 1'b0;
            addr_r       <= 30'd0;
            wdata_r      <= 32'd0;
            grant        <= 2'b00;
            busy         <= 1'b0;
            cpu_ready    <= 1'b0;
            cpu_err      <= 1'b0;
            cpu_rdata    <= 32'd0;
            host_ready   <= 1'b0;
            host_err     <= 1'b0;
            host_rdata   <= 32'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (cpu_req || host_req) begin
                        state_r      <= ACCESS;
                        owner_r      <= grant_host_s;
                        last_grant_r <= grant_host_s;
                        grant        <= grant_host_s ? 2'b10 : 2'b01;
                        busy         <= 1'b1;
                        we_r         <= grant_host_s ? host_we : cpu_we;
                        addr_r       <= grant_host_s ? host_addr[31:2] : cpu_addr[31:2];
                        wdata_r      <= grant_host_s ? host_wdata : cpu_wdata;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    state_r <= RESP;
                    if (owner_r == OWNER_HOST) begin
                        host_ready <= 1'b1;
                        host_rdata <= result_s;
                        host_err   <= oor_s;
                    end else begin
                        cpu_ready <= 1'b1;
                        cpu_rdata <= result_s;
                        cpu_err   <= oor_s;
                    end
                end
                RESP: begin
                    state_r    <= IDLE;
                    grant      <= 2'b00;
                    busy       <= 1'b0;
                    cpu_ready  <= 1'b0;
                    cpu_err    <= 1'b0;
                    host_ready <= 1'b0;
                    host_err   <= 1'b0;
                end
                default: begin
                    state_r    <= IDLE;
                    grant      <= 2'b00;
                    busy       <= 1'b0;
                    cpu_ready  <= 1'b0;
                    cpu_err    <= 1'b0;
                    host_ready <= 1'b0;
                    host_err   <= 1'b0;
                end
            endcase
        end
    end

    // Storage array; out-of-range writes are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 32'd0;
            end
        end else if (state_r == ACCESS && we_r && !oor_s) begin
            mem_r[idx_s] <= wdata_r;
        end
    end

    assign mem_word0 = mem_r[0];

`ifdef DMEM_ARB_STATS_EN
    // Saturating grant and conflict statistics.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_grants  <= 16'd0;
            host_grants <= 16'd0;
            conflicts   <= 16'd0;
        end else if (state_r == IDLE) begin
            if (conflict_s && conflicts != 16'hFFFF) begin
                conflicts <= conflicts + 16'd1;
            end
            if ((cpu_req || host_req) && grant_host_s && host_grants != 16'hFFFF) begin
                host_grants <= host_grants + 16'd1;
            end
            if ((cpu_req || host_req) && !grant_host_s && cpu_grants != 16'hFFFF) begin
                cpu_grants <= cpu_grants + 16'd1;
            end
        end
    end
`endif

endmodule
